// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction-fetch front end with a DEPTH-entry prefetch FIFO.
// Issues sequential word-addressed fetches to the I-cache (one outstanding at most),
// buffers {instruction, PC} pairs so decode stalls do not stall fetch, and flushes
// on branch/call/return redirects, discarding any in-flight response.
//
// Optional feature: define IF_BYPASS_EN to forward a response straight to decode
// when the queue is empty (zero-cycle response-to-decode latency).
//
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   stall_i               decode not accepting; head is held
//   redirect_valid_i/pc_i redirect fetch to a new target, flush queue
//   ic_req_valid_o/addr_o fetch request to cache (addr = fetch_pc)
//   ic_req_ready_i        cache accepts request
//   ic_resp_valid_i/data_i instruction for the outstanding request
//   instr_valid_o, instr_o, instr_pc_o  queue head (zeroed when not valid)
//   fetch_pc_o            next address to fetch
//   occupancy_o           entries currently queued
module if_prefetch_queue #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 16,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall_i,
  input  logic                       redirect_valid_i,
  input  logic [ADDR_W-1:0]          redirect_pc_i,
  output logic                       ic_req_valid_o,
  output logic [ADDR_W-1:0]          ic_req_addr_o,
  input  logic                       ic_req_ready_i,
  input  logic                       ic_resp_valid_i,
  input  logic [INSTR_W-1:0]         ic_resp_data_i,
  output logic                       instr_valid_o,
  output logic [INSTR_W-1:0]         instr_o,
  output logic [ADDR_W-1:0]          instr_pc_o,
  output logic [ADDR_W-1:0]          fetch_pc_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned OccW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StRun, StWait, StDrop} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]    req_pc_q, req_pc_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OccW-1:0]      count_q, count_d;
  logic [INSTR_W-1:0]   data_q [DEPTH];
  logic [ADDR_W-1:0]    pc_q   [DEPTH];

  logic q_nonempty, hs, resp_ok, bypass, q_push, q_pop;

  assign q_nonempty     = (count_q != '0);
  // Gated by rst so the request is low throughout reset, even before the first edge.
  assign ic_req_valid_o = rst && (state_q == StRun) && (count_q < OccW'(DEPTH));
  assign hs             = ic_req_valid_o && ic_req_ready_i;
  assign resp_ok        = (state_q == StWait) && ic_resp_valid_i && !redirect_valid_i;

`ifdef IF_BYPASS_EN
  assign bypass = rst && !q_nonempty && resp_ok;
  // A bypassed instruction taken by decode this cycle is never written.
  assign q_push = resp_ok && !(bypass && !stall_i);
`else
  assign bypass = 1'b0;
  assign q_push = resp_ok;
`endif

  assign q_pop         = q_nonempty && !stall_i && !redirect_valid_i;
  assign instr_valid_o = rst && (q_nonempty || bypass);
  assign ic_req_addr_o = fetch_pc_q;
  assign fetch_pc_o    = fetch_pc_q;
  assign occupancy_o   = count_q;

  always_comb begin
    instr_o    = '0;
    instr_pc_o = '0;
    if (rst && q_nonempty) begin
      instr_o    = data_q[rd_ptr_q];
      instr_pc_o = pc_q[rd_ptr_q];
    end else if (bypass) begin
      instr_o    = ic_resp_data_i;
      instr_pc_o = req_pc_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    unique case (state_q)
      StRun: begin
        if (hs) begin
          state_d    = StWait;
          req_pc_d   = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 1'b1;
        end
      end
      StWait:  if (ic_resp_valid_i) state_d = StRun;
      StDrop:  if (ic_resp_valid_i) state_d = StRun;
      default: state_d = StRun;
    endcase

    if (q_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (q_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({q_push, q_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase

    // Redirect overrides everything: flush, retarget, and mark any request that is
    // (or is about to become) outstanding as stale.
    if (redirect_valid_i) begin
      fetch_pc_d = redirect_pc_i;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      if (state_q == StRun) state_d = hs ? StDrop : StRun;
      else                  state_d = ic_resp_valid_i ? StRun : StDrop;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (rst && q_push) begin
      data_q[wr_ptr_q] <= ic_resp_data_i;
      pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

endmodule
